mdu_issue_ctrl: RTL and testbench
=================================

Name: mdu_issue_ctrl

Overview:
EX-stage initiator for the multi-cycle multiply/divide unit. It is the requesting end of the compute/finished protocol that the MDU answers.
- Accepts an MDU instruction from the OP stage and latches its operands and function.
- Holds the compute request stable until the MDU reports finished, then captures the result and presents it to MA.
- Generates the EX stall and aborts cleanly on pipeline flush or on a watchdog timeout.

Parameters:
TIMEOUT, 40, max cycles in BUSY before an abort (must be >= 35 for radix-2 division)
CNT_W, $clog2(TIMEOUT+1), width of the cycle counter

Ports:
s_clk_i  in  1  clock
s_rst_i  in  1  reset, asynchronous, active-high
s_valid_i  in  1  OP stage presents an MDU instruction
s_func_i  in  3  MDU function (funct3: MUL..REMU)
s_op1_i  in  32  operand 1
s_op2_i  in  32  operand 2
s_ma_stall_i  in  1  MA stage cannot accept a result this cycle
s_flush_i  in  1  pipeline flush from MA
s_mdu_finished_i  in  1  MDU finished (1-cycle pulse)
s_mdu_result_i  in  32  MDU result, valid with finished
s_mdu_compute_o  out  1  compute request to MDU
s_mdu_func_o  out  3  latched function
s_mdu_op1_o  out  32  latched operand 1
s_mdu_op2_o  out  32  latched operand 2
s_ex_stall_o  out  1  stall OP/EX upstream
s_result_o  out  32  captured result
s_result_valid_o  out  1  result available to MA
s_timeout_o  out  1  1-cycle pulse on watchdog abort

Behaviour:
- Reset (async, any state): state=IDLE, counter=0. All outputs 0; latched operands, function and result are 0.
- States: IDLE, BUSY, DONE. Encoding is free; no illegal state may persist (default -> IDLE).
- IDLE:
  - s_valid_i & !s_flush_i: latch op1/op2/func, counter<=0, go to BUSY.
  - s_ex_stall_o = s_valid_i & !s_flush_i (combinational).
- BUSY:
  - s_mdu_compute_o=1; latched operands and function held constant; s_ex_stall_o=1; counter increments each cycle.
  - s_mdu_finished_i: result<=s_mdu_result_i, go to DONE.
  - Else if counter==TIMEOUT-1: result<=0, s_timeout_o=1 for that one cycle, go to DONE.
  - Finished and the timeout condition in the same cycle: finished wins, and s_timeout_o stays 0.
- DONE:
  - s_result_valid_o=1 and s_mdu_compute_o=0.
  - s_ex_stall_o=1 only while s_ma_stall_i=1.
  - !s_ma_stall_i: result is consumed, go to IDLE.
  - No back-to-back acceptance from DONE: a new instruction is accepted in IDLE only, which gives one bubble between MDU operations.
- Flush: s_flush_i in any state -> IDLE next cycle.
  - Combinationally forces s_mdu_compute_o=0, s_result_valid_o=0 and s_ex_stall_o=0 in that same cycle.
  - Counter cleared; the latched result is not updated.
  - A s_mdu_finished_i arriving in the flush cycle is ignored.
- Flush has priority over finished, timeout and s_valid_i.
- A stray s_mdu_finished_i in IDLE or DONE is ignored.
- Latency: valid in IDLE at cycle 0 -> compute from cycle 1. Finished at cycle k -> s_result_valid_o from cycle k+1.
- Counter saturates at TIMEOUT-1 and never wraps.

Test Plan:
- MUL 7*6: valid at c0, finished with 42 at c3 -> compute=1 c1–c3; result_valid=1, result=42 at c4; stall=1 c0–c3 and 0 at c4; IDLE at c5.
- Result held under MA stall: as above with s_ma_stall_i=1 c4–c6 -> result_valid and result=42 held c4–c7, stall=1 c4–c6, IDLE at c8.
- Flush mid-operation: DIV 100/7 accepted, flush at BUSY cycle 5 together with finished -> compute=0 and stall=0 that cycle; next cycle IDLE, result_valid never asserted, result unchanged.
- Watchdog: finished never asserted, TIMEOUT=40 -> s_timeout_o pulses once at BUSY cycle 40; result_valid=1 with result=0 the following cycle.
- Finished coincides with counter==TIMEOUT-1 -> result=MDU value, s_timeout_o=0.
- Async reset asserted mid-BUSY between clock edges -> all outputs 0 immediately; after release with s_valid_i=1 a new operation is accepted on the first clock edge.

Source files
------------

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: EX-stage initiator for the multi-cycle multiply/divide unit.
// It latches an MDU instruction from OP, holds the compute request stable
// until the MDU pulses finished, then presents the captured result to MA.
// It stalls upstream while an operation is in flight. A pipeline flush or a
// watchdog expiry ends the operation early.
module mdu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_valid_i,
  input  logic [2:0]  s_func_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic        s_ma_stall_i,
  input  logic        s_flush_i,
  input  logic        s_mdu_finished_i,
  input  logic [31:0] s_mdu_result_i,
  output logic        s_mdu_compute_o,
  output logic [2:0]  s_mdu_func_o,
  output logic [31:0] s_mdu_op1_o,
  output logic [31:0] s_mdu_op2_o,
  output logic        s_ex_stall_o,
  output logic [31:0] s_result_o,
  output logic        s_result_valid_o,
  output logic        s_timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // This is the last BUSY cycle before the watchdog gives up. It is also the
  // value where the counter stops.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [2:0]        func_q,  func_d;
  logic [31:0]       op1_q,   op1_d;
  logic [31:0]       op2_q,   op2_d;
  logic [31:0]       result_q, result_d;

  logic              compute;
  logic              ex_stall;
  logic              result_valid;
  logic              timeout;

  // State, counter, latched request and captured result.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // update together from values computed before the edge.
  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      func_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
    end
  end

  // Next-state and output decode. A flush overrides the per-state decision.
  always_comb begin
    // NOTE: every signal gets a default value before the case statement.
    // A path that does not assign a signal therefore keeps its value through
    // the default, and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    func_d       = func_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    result_d     = result_q;
    compute      = 1'b0;
    ex_stall     = 1'b0;
    result_valid = 1'b0;
    timeout      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid_i && !s_flush_i) begin
          func_d   = s_func_i;
          op1_d    = s_op1_i;
          op2_d    = s_op2_i;
          cnt_d    = '0;
          ex_stall = 1'b1;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        compute  = 1'b1;
        ex_stall = 1'b1;
        // The counter stops at the watchdog limit and never wraps.
        cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        if (s_mdu_finished_i) begin
          // A finished pulse takes priority over a watchdog expiry in the same cycle.
          result_d = s_mdu_result_i;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          timeout  = 1'b1;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        result_valid = 1'b1;
        ex_stall     = s_ma_stall_i;
        // No new instruction is accepted here. This leaves one bubble
        // between MDU operations.
        if (!s_ma_stall_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A flush drops the operation at once. Any finished pulse in this cycle
    // is ignored, and the captured result keeps its old value.
    if (s_flush_i) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      func_d       = func_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      result_d     = result_q;
      compute      = 1'b0;
      ex_stall     = 1'b0;
      result_valid = 1'b0;
      timeout      = 1'b0;
    end
  end

  // Drive the outputs. The stall depends directly on s_valid_i in IDLE, so it
  // is also forced low while reset is asserted.
  assign s_mdu_compute_o  = compute;
  assign s_mdu_func_o     = func_q;
  assign s_mdu_op1_o      = op1_q;
  assign s_mdu_op2_o      = op2_q;
  assign s_ex_stall_o     = ex_stall && !s_rst_i;
  assign s_result_o       = result_q;
  assign s_result_valid_o = result_valid;
  assign s_timeout_o      = timeout;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl. It checks cycle-exact protocol
// behaviour directly and uses a scoreboard for every result that MA consumes.
`timescale 1ns/1ps
module tb_mdu_issue_ctrl;

  localparam int unsigned TIMEOUT = 40;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  func;
  logic [31:0] op1, op2;
  logic        ma_stall;
  logic        flush;
  logic        finished;
  logic [31:0] mdu_result;
  logic        compute;
  logic [2:0]  mdu_func;
  logic [31:0] mdu_op1, mdu_op2;
  logic        ex_stall;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb_q[$];

  mdu_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .s_clk_i          (clk),
    .s_rst_i          (rst),
    .s_valid_i        (valid),
    .s_func_i         (func),
    .s_op1_i          (op1),
    .s_op2_i          (op2),
    .s_ma_stall_i     (ma_stall),
    .s_flush_i        (flush),
    .s_mdu_finished_i (finished),
    .s_mdu_result_i   (mdu_result),
    .s_mdu_compute_o  (compute),
    .s_mdu_func_o     (mdu_func),
    .s_mdu_op1_o      (mdu_op1),
    .s_mdu_op2_o      (mdu_op2),
    .s_ex_stall_o     (ex_stall),
    .s_result_o       (result),
    .s_result_valid_o (result_valid),
    .s_timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard: each result that MA consumes must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && result_valid && !ma_stall && !flush) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", result, 32'hxxxx_xxxx);
      end else begin
        check("sb_result", result, sb_q.pop_front());
      end
    end
  end

  // Start a new cycle: wait for the posedge, then move off it to drive inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1;
    func  = f;
    op1   = a;
    op2   = b;
  endtask

  int pulses;
  int pulse_cyc;

  initial begin
    rst = 1'b1; valid = 1'b0; func = '0; op1 = '0; op2 = '0;
    ma_stall = 1'b0; flush = 1'b0; finished = 1'b0; mdu_result = '0;
    repeat (2) neg();
    check("rst_compute", {31'd0, compute}, 32'd0);
    check("rst_stall", {31'd0, ex_stall}, 32'd0);
    check("rst_rvalid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_op1", mdu_op1, 32'd0);
    rst = 1'b0;

    // MUL 7*6. The MDU finishes at c3, and the result is consumed at c4.
    tick(); issue(3'd0, 32'd7, 32'd6); sb_q.push_back(32'd42);        // c0
    neg(); check("mul_c0_stall", {31'd0, ex_stall}, 32'd1);
    check("mul_c0_compute", {31'd0, compute}, 32'd0);
    tick(); valid = 1'b0; op1 = 32'hffff_ffff; op2 = 32'hffff_ffff;   // c1
    neg(); check("mul_c1_compute", {31'd0, compute}, 32'd1);
    check("mul_c1_op1", mdu_op1, 32'd7);
    check("mul_c1_op2", mdu_op2, 32'd6);
    tick();                                                            // c2
    neg(); check("mul_c2_compute", {31'd0, compute}, 32'd1);
    tick(); finished = 1'b1; mdu_result = 32'd42;                      // c3
    neg(); check("mul_c3_compute", {31'd0, compute}, 32'd1);
    check("mul_c3_stall", {31'd0, ex_stall}, 32'd1);
    tick(); finished = 1'b0; mdu_result = 32'hdead_beef;               // c4
    neg(); check("mul_c4_rvalid", {31'd0, result_valid}, 32'd1);
    check("mul_c4_stall", {31'd0, ex_stall}, 32'd0);
    check("mul_c4_compute", {31'd0, compute}, 32'd0);
    tick();                                                            // c5
    neg(); check("mul_c5_rvalid", {31'd0, result_valid}, 32'd0);
    check("mul_c5_stall", {31'd0, ex_stall}, 32'd0);

    // The result is held while MA stalls from c4 to c6.
    tick(); issue(3'd0, 32'd3, 32'd5); sb_q.push_back(32'd15);        // c0
    tick(); valid = 1'b0;                                              // c1
    tick();                                                            // c2
    tick(); finished = 1'b1; mdu_result = 32'd15;                      // c3
    tick(); finished = 1'b0; ma_stall = 1'b1;                          // c4
    for (int c = 4; c <= 6; c++) begin
      if (c > 4) tick();
      neg();
      check($sformatf("hold_c%0d_rvalid", c), {31'd0, result_valid}, 32'd1);
      check($sformatf("hold_c%0d_result", c), result, 32'd15);
      check($sformatf("hold_c%0d_stall", c), {31'd0, ex_stall}, 32'd1);
    end
    tick(); ma_stall = 1'b0;                                           // c7
    neg(); check("hold_c7_rvalid", {31'd0, result_valid}, 32'd1);
    check("hold_c7_stall", {31'd0, ex_stall}, 32'd0);
    tick();                                                            // c8
    neg(); check("hold_c8_rvalid", {31'd0, result_valid}, 32'd0);

    // DIV 100/7 is flushed in BUSY cycle 5, together with a finished pulse.
    tick(); issue(3'd4, 32'd100, 32'd7);                               // c0
    tick(); valid = 1'b0;                                              // c1
    neg(); check("div_c1_func", {29'd0, mdu_func}, 32'd4);
    repeat (3) tick();                                                 // c2..c4
    tick(); flush = 1'b1; finished = 1'b1; mdu_result = 32'd14;        // c5
    neg(); check("flush_compute", {31'd0, compute}, 32'd0);
    check("flush_stall", {31'd0, ex_stall}, 32'd0);
    check("flush_rvalid", {31'd0, result_valid}, 32'd0);
    tick(); flush = 1'b0; finished = 1'b0;                             // c6
    neg(); check("flush_c6_compute", {31'd0, compute}, 32'd0);
    check("flush_c6_rvalid", {31'd0, result_valid}, 32'd0);
    check("flush_c6_result", result, 32'd15);
    // A stray finished pulse in IDLE must not produce a result.
    tick(); finished = 1'b1; mdu_result = 32'd99;
    tick(); finished = 1'b0;
    neg(); check("stray_rvalid", {31'd0, result_valid}, 32'd0);
    check("stray_result", result, 32'd15);

    // Watchdog: finished never arrives, so BUSY cycle 40 aborts the operation.
    tick(); issue(3'd1, 32'd11, 32'd13); sb_q.push_back(32'd0);       // c0
    pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 41; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      neg();
      if (timeout) begin
        pulses++;
        pulse_cyc = c;
      end
      if (c == 41) begin
        check("wd_rvalid", {31'd0, result_valid}, 32'd1);
        check("wd_result", result, 32'd0);
      end
    end
    check("wd_pulses", pulses, 32'd1);
    check("wd_pulse_cycle", pulse_cyc, 32'd40);
    tick();

    // Finished coincides with the last watchdog cycle, so finished wins.
    tick(); issue(3'd5, 32'd500, 32'd3); sb_q.push_back(32'h1234_5678); // c0
    for (int c = 1; c <= 41; c++) begin
      tick();
      if (c == 1) valid = 1'b0;
      if (c == 40) begin
        finished = 1'b1;
        mdu_result = 32'h1234_5678;
      end
      if (c == 41) finished = 1'b0;
      neg();
      if (c == 40) check("tie_timeout", {31'd0, timeout}, 32'd0);
      if (c == 41) check("tie_result", result, 32'h1234_5678);
    end
    tick();

    // Asynchronous reset during BUSY, then accept an instruction on the first edge.
    tick(); issue(3'd0, 32'd9, 32'd9);                                 // c0
    tick(); valid = 1'b0;                                              // c1
    tick();                                                            // c2
    #1 rst = 1'b1;
    #1;
    check("arst_compute", {31'd0, compute}, 32'd0);
    check("arst_stall", {31'd0, ex_stall}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_op1", mdu_op1, 32'd0);
    check("arst_rvalid", {31'd0, result_valid}, 32'd0);
    #1 rst = 1'b0;
    issue(3'd0, 32'd2, 32'd21); sb_q.push_back(32'd42);
    neg(); check("arst_new_stall", {31'd0, ex_stall}, 32'd1);
    tick(); valid = 1'b0;
    neg(); check("arst_new_compute", {31'd0, compute}, 32'd1);
    check("arst_new_op1", mdu_op1, 32'd2);
    tick(); finished = 1'b1; mdu_result = 32'd42;
    tick(); finished = 1'b0;
    neg(); check("arst_new_rvalid", {31'd0, result_valid}, 32'd1);
    tick(); tick();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
